// File: rtl/pio_crc_pkg.sv
// Shared definitions for the PIO-driven CRC-32 engine: command opcodes,
// FSM state type, CRC-32 constants and the bit layout of the PIO words.
package pio_crc_pkg;

  // Command opcodes carried in pio_word[22:21]
  localparam logic [1:0] OP_FEED = 2'b00;
  localparam logic [1:0] OP_INIT = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Engine is either waiting for a command or shifting one byte
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Standard reflected CRC-32 (IEEE 802.3 / zlib)
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_SEED      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  // Command word field positions
  localparam int PIO_W        = 24;
  localparam int PIO_REQ_BIT  = 23;
  localparam int PIO_OP_MSB   = 22;
  localparam int PIO_OP_LSB   = 21;
  localparam int PIO_IGN_MSB  = 20;
  localparam int PIO_IGN_LSB  = 8;
  localparam int PIO_DATA_MSB = 7;

  // status_out field positions
  localparam int STAT_ACK_BIT   = 31;
  localparam int STAT_BUSY_BIT  = 30;
  localparam int STAT_ERR_BIT   = 29;
  localparam int STAT_COUNT_W   = 16;
  localparam int STAT_PAD_W     = 13;

endpackage

// File: rtl/pio_crc32_engine_step.sv
// One bit of a reflected CRC-32 LFSR. Purely combinational so a
// byte-parallel version is simply eight of these chained.
module crc32_bit_step
  import pio_crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic        data_bit,
  input  logic [31:0] poly,
  output logic [31:0] crc_next
);

  logic feedback;

  assign feedback = crc_in[0] ^ data_bit;

  // Shift right and fold in the polynomial when the feedback bit is set
  always_comb begin
    // NOTE: assigning a default first means every path drives crc_next,
    // so no latch can be inferred however the conditions below evolve.
    crc_next = crc_in >> 1;
    if (feedback) begin
      crc_next = crc_next ^ poly;
    end
  end

endmodule

// File: rtl/pio_crc32_engine.sv
// Bit-serial CRC-32 engine behind a 24-bit PIO output port. Software writes
// a toggle-handshake command word (req/opcode/data); the engine acknowledges
// by copying req into ack once the command has completed. FEED folds one
// byte into the CRC, one bit per clock, LSB first.
module pio_crc32_engine
  import pio_crc_pkg::*;
#(
  parameter logic [31:0] POLY   = CRC32_POLY_REFL,
  parameter logic [31:0] SEED   = CRC32_SEED,
  parameter logic [31:0] XOROUT = CRC32_XOROUT,
  parameter int          CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PIO_W-1:0]    pio_word,
  output logic [31:0]         crc_out,
  output logic [31:0]         status_out,
  output logic                busy
);

  state_t            state;
  logic [31:0]       crc_reg;
  logic [31:0]       crc_next;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic              req_cap;
  logic              ack;
  logic              err;
  logic [CNT_W-1:0]  byte_count;
  logic [STAT_COUNT_W-1:0] count_field;

  // Command word fields
  logic              req;
  logic [1:0]        opcode;
  logic [7:0]        data;
  logic              pending;
  logic              unused_pio_bits;

  assign req     = pio_word[PIO_REQ_BIT];
  assign opcode  = pio_word[PIO_OP_MSB:PIO_OP_LSB];
  assign data    = pio_word[PIO_DATA_MSB:0];
  assign unused_pio_bits = ^pio_word[PIO_IGN_MSB:PIO_IGN_LSB];

  // Level compare: any req/ack disagreement while idle is a new command,
  // including a req already high when reset is released.
  assign pending = (state == IDLE) && (req != ack);

  crc32_bit_step u_step (
    .crc_in   (crc_reg),
    .data_bit (shift_reg[0]),
    .poly     (POLY),
    .crc_next (crc_next)
  );

  // Command decode, bit-serial shift and handshake state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      crc_reg    <= SEED;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      req_cap    <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      byte_count <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would let later lines see updated state.
      case (state)
        IDLE: begin
          if (pending) begin
            case (opcode)
              OP_FEED: begin
                // Byte and req are latched now; pio_word may change freely
                // while the byte shifts.
                shift_reg <= data;
                req_cap   <= req;
                bit_cnt   <= '0;
                state     <= SHIFT;
              end
              OP_INIT: begin
                crc_reg    <= SEED;
                byte_count <= '0;
                err        <= 1'b0;
                ack        <= req;
              end
              OP_NOP: begin
                ack <= req;
              end
              default: begin
                // Reserved opcode: flag it, acknowledge, leave CRC alone
                err <= 1'b1;
                ack <= req;
              end
            endcase
          end
        end

        SHIFT: begin
          crc_reg   <= crc_next;
          shift_reg <= {1'b0, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_count <= byte_count + CNT_W'(1);
            ack        <= req_cap;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The byte counter is reported in a fixed 16-bit field
  generate
    if (CNT_W >= STAT_COUNT_W) begin : g_count_trunc
      assign count_field = byte_count[STAT_COUNT_W-1:0];
    end else begin : g_count_ext
      assign count_field = {{(STAT_COUNT_W-CNT_W){1'b0}}, byte_count};
    end
  endgenerate

  // Outputs are taken straight from registers; pio_word never reaches them
  assign busy       = (state == SHIFT);
  assign crc_out    = crc_reg ^ XOROUT;
  assign status_out = {ack, busy, err, {STAT_PAD_W{1'b0}}, count_field};

endmodule

// File: doc/pio_crc32_engine.md
# pio_crc32_engine

Bit-serial CRC-32 engine that sits directly downstream of the 24-bit Avalon PIO output port in the Nios CRC platform. It decodes the PIO word as a toggle-handshake command (init / feed byte / nop) and folds each fed byte into a running reflected CRC-32, one bit per clock. The result and a status word are presented for capture by input PIOs, so software drives the engine with plain PIO writes and reads.

## Interface
Parameters:
- POLY, 32'hEDB88320, reflected CRC-32 polynomial
- SEED, 32'hFFFFFFFF, register value after reset and on init
- XOROUT, 32'hFFFFFFFF, final XOR applied to crc_out
- CNT_W, 16, byte counter width

Ports:
- clk  input  1  clock
- reset_n  input  1  reset reset_n, asynchronous, active-low; clock clk
- pio_word  input  24  command word from PIO out_port: [23] req toggle, [22:21] opcode, [20:8] ignored, [7:0] data byte
- crc_out  output  32  crc_reg ^ XOROUT
- status_out  output  32  {ack, busy, err, 13'b0, byte_count[15:0]} (byte_count zero-extended or truncated to 16 bits)
- busy  output  1  high while a byte is shifting

## Operation
- Opcodes: 2'b00 FEED, 2'b01 INIT, 2'b10 NOP, 2'b11 reserved.
- Request pending when pio_word[23] != ack and state is IDLE. Level compare, not edge detect.
- States: IDLE, SHIFT.
- IDLE + pending FEED: capture data byte into shift_reg, capture req bit, bit_cnt <= 0, go to SHIFT.
- IDLE + pending INIT: crc_reg <= SEED, byte_count <= 0, err <= 0, ack <= req, stay IDLE.
- IDLE + pending NOP: ack <= req only.
- IDLE + pending reserved: err <= 1 (sticky until INIT or reset), ack <= req, crc unchanged.
- SHIFT, each cycle: fb = crc_reg[0] ^ shift_reg[0]; crc_reg <= (crc_reg >> 1) ^ (fb ? POLY : 0); shift_reg >>= 1; bit_cnt++.
- SHIFT with bit_cnt == 7: last step as above, byte_count++ (wraps modulo 2^CNT_W), ack <= captured req, go to IDLE.
- pio_word is sampled only at acceptance. Changes during SHIFT do not affect the current byte.
- A single req toggle during SHIFT is serviced on the first IDLE cycle. A double toggle during SHIFT leaves req == ack and is not serviced. Software must wait for ack == req before the next write.
- Reset values: crc_reg = SEED (crc_out = 32'h00000000 with defaults), ack = 0, busy = 0, err = 0, byte_count = 0, state IDLE.
- Reset asserted mid-SHIFT aborts the byte; all registers go to reset values immediately.
- pio_word[23] = 1 at reset release is a pending request and is serviced.

## Timing
- All outputs are registered; no combinational path from pio_word to any output.
- FEED accepted at edge E0: busy high after E0. Last shift, ack toggle, byte_count and crc_out update at E8; busy low after E8. Accept-to-ack is 8 clocks; back-to-back throughput is 9 clocks per byte (one IDLE cycle).
- INIT, NOP and reserved opcodes complete at the acceptance edge E0 (1 clock).
- PIO write to ack visible: PIO register edge + 1 edge (acceptance) + 8 edges for FEED.

## Structure
- Package pio_crc_pkg holds:
  - opcode localparams OP_FEED, OP_INIT, OP_NOP, OP_RSVD
  - state enum {IDLE, SHIFT}
  - CRC32_POLY_REFL and CRC32_SEED constants
  - status_out bit-position constants
- Sub-module crc32_bit_step: combinational single LFSR step (crc_in, data_bit, poly → crc_next), instantiated once. This keeps a later 8-bit-parallel variant a drop-in unroll.

## Test plan
- Reset: assert reset_n = 0 mid-run → crc_out = 32'h00000000, status_out = 32'h0, busy = 0 within the same cycle.
- INIT, then FEED ASCII "123456789" (each byte with toggled req, waiting for ack) → crc_out = 32'hCBF43926, byte_count = 9, err = 0.
- INIT, then FEED 8'h00 → busy high for exactly 8 clocks, ack toggles at E8, crc_out = 32'hD202EF8D, byte_count = 1.
- Reserved opcode 2'b11 → err = 1, ack toggles at E0, crc_out and byte_count unchanged; subsequent INIT → err = 0.
- Toggle req once during SHIFT with a new byte → second byte accepted on first IDLE cycle, two acks total. Toggle twice during SHIFT → no extra byte, byte_count unchanged.
- Byte counter wrap: preload via 65536 FEEDs (or a CNT_W = 4 build with 16 FEEDs) → byte_count returns to 0, CRC unaffected.
